// File: rtl/red_pitaya_acq_ch_if.sv
// Bundles the sample input, trigger/config inputs, readback port and status of one
// acquisition channel. Latency: none, wires only.
// Backpressure: none. The acquisition side uses the slave modport.
// Signal names keep the channel's own _i/_o direction (as seen by the channel).
interface red_pitaya_acq_ch_if #(
    parameter int RSZ = 14
);
    logic [13:0]    adc_dat_i;
    logic           trig_sw_i;
    logic           trig_ext_i;
    logic [2:0]     trig_src_i;
    logic           set_arm_i;
    logic           set_rst_i;
    logic [16:0]    set_dec_i;
    logic [13:0]    set_tresh_i;
    logic [13:0]    set_hyst_i;
    logic [31:0]    set_dly_i;
    logic [RSZ-1:0] buf_addr_i;
    logic [13:0]    buf_rdata_o;
    logic [RSZ-1:0] buf_wpnt_o;
    logic [RSZ-1:0] trig_pnt_o;
    logic           trig_o;
    logic           sts_armed_o;
    logic           sts_done_o;

    // scope/control side
    modport master (
        output adc_dat_i, trig_sw_i, trig_ext_i, trig_src_i, set_arm_i, set_rst_i,
               set_dec_i, set_tresh_i, set_hyst_i, set_dly_i, buf_addr_i,
        input  buf_rdata_o, buf_wpnt_o, trig_pnt_o, trig_o, sts_armed_o, sts_done_o
    );

    // acquisition channel side
    modport slave (
        input  adc_dat_i, trig_sw_i, trig_ext_i, trig_src_i, set_arm_i, set_rst_i,
               set_dec_i, set_tresh_i, set_hyst_i, set_dly_i, buf_addr_i,
        output buf_rdata_o, buf_wpnt_o, trig_pnt_o, trig_o, sts_armed_o, sts_done_o
    );
endinterface

// File: rtl/red_pitaya_acq_ch.sv
// Single ADC channel capture into a 2^RSZ circular buffer with decimation and trigger FSM.
// Latency: sample registered once (s1), written on the next decimation strobe; readback 1 cycle.
// Backpressure: none; the ADC stream is never stalled, writes simply stop in IDLE/DONE.
// Ports: adc_clk_i (all logic), adc_rst_i (async active-high), bus (red_pitaya_acq_ch_if.slave).
// Build option ACQ_AVG_EN: store the mean of each decimation window instead of the strobe sample.
module red_pitaya_acq_ch #(
    parameter int RSZ = 14
) (
    input  logic               adc_clk_i,
    input  logic               adc_rst_i,
    red_pitaya_acq_ch_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_TRIGD = 2'd2, S_DONE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic signed [13:0] s1_q;
    logic [16:0]        dec_n, dec_cnt_q, dec_cnt_d;
    logic [RSZ-1:0]     wpnt_q, wpnt_d, tpnt_q, tpnt_d;
    logic [31:0]        dly_q, dly_d;
    logic               seen_q, seen_d;      // a sample was written since the last arm
    logic               rf_r_q, rf_r_d, rf_f_q, rf_f_d;
    logic               ext_q, trig_q;
    logic               active, strobe, trig_ev, accept, fire_r, fire_f;
    logic signed [14:0] s1_x, thr_x, lo_x, hi_x;
    logic [13:0]        mem [0:(1<<RSZ)-1];
    logic [13:0]        rdata_q;
    logic               wr_en;
    logic [RSZ-1:0]     wr_addr;
    logic [13:0]        wr_dat;

    // ---------------- trigger sources ----------------
    assign s1_x   = {s1_q[13], s1_q};
    assign thr_x  = {bus.set_tresh_i[13], bus.set_tresh_i};
    assign lo_x   = thr_x - $signed({1'b0, bus.set_hyst_i});
    assign hi_x   = thr_x + $signed({1'b0, bus.set_hyst_i});
    assign fire_r = rf_r_q && (s1_x >= thr_x);
    assign fire_f = rf_f_q && (s1_x <= thr_x);

    // Rearm flags: armed by leaving the hysteresis band, consumed by a crossing.
    always_comb begin
        rf_r_d = rf_r_q;
        rf_f_d = rf_f_q;
        if (bus.set_arm_i) begin
            rf_r_d = 1'b0;
            rf_f_d = 1'b0;
        end else begin
            if (s1_x < lo_x)  rf_r_d = 1'b1;
            else if (fire_r)  rf_r_d = 1'b0;
            if (s1_x > hi_x)  rf_f_d = 1'b1;
            else if (fire_f)  rf_f_d = 1'b0;
        end
    end

    always_comb begin
        case (bus.trig_src_i)
            3'd1:    trig_ev = bus.trig_sw_i;
            3'd2:    trig_ev = fire_r;
            3'd3:    trig_ev = fire_f;
            3'd4:    trig_ev = bus.trig_ext_i & ~ext_q;
            3'd5:    trig_ev = ~bus.trig_ext_i & ext_q;
            default: trig_ev = 1'b0;
        endcase
    end

    // Arm and FSM reset both mask the strobe and any trigger in their cycle.
    assign dec_n  = (bus.set_dec_i == '0) ? 17'd1 : bus.set_dec_i;
    assign strobe = active && !bus.set_arm_i && !bus.set_rst_i && (dec_cnt_q == dec_n - 17'd1);
    assign accept = (state_q == S_ARMED) && trig_ev && !bus.set_arm_i && !bus.set_rst_i;

    // ---------------- FSM ----------------
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.set_rst_i)      state_d = S_IDLE;
        else if (bus.set_arm_i) state_d = S_ARMED;
        else begin
            case (state_q)
                S_ARMED: if (accept) state_d = (bus.set_dly_i == '0) ? S_DONE : S_TRIGD;
                S_TRIGD: if (strobe && dly_q <= 32'd1) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        active          = (state_q == S_ARMED) || (state_q == S_TRIGD);
        bus.sts_armed_o = active;
        bus.sts_done_o  = (state_q == S_DONE);
    end

    // ---------------- counters and pointers ----------------
    always_comb begin
        dec_cnt_d = '0;
        wpnt_d    = wpnt_q;
        tpnt_d    = tpnt_q;
        dly_d     = dly_q;
        seen_d    = seen_q;
        if (bus.set_rst_i) begin
            wpnt_d = '0;
            tpnt_d = '0;
            dly_d  = '0;
            seen_d = 1'b0;
        end else if (bus.set_arm_i) begin
            dly_d  = '0;
            seen_d = 1'b0;
        end else begin
            if (active && !strobe) dec_cnt_d = dec_cnt_q + 17'd1;
            if (accept) begin
                // point at the newest sample already in the buffer, not the one being written now
                tpnt_d = seen_q ? wpnt_q - RSZ'(1) : wpnt_q;
                dly_d  = bus.set_dly_i;
            end else if (strobe && state_q == S_TRIGD) begin
                dly_d = dly_q - 32'd1;
            end
            if (strobe) begin
                wpnt_d = wpnt_q + RSZ'(1);
                seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            s1_q      <= '0;
            dec_cnt_q <= '0;
            wpnt_q    <= '0;
            tpnt_q    <= '0;
            dly_q     <= '0;
            seen_q    <= 1'b0;
            rf_r_q    <= 1'b0;
            rf_f_q    <= 1'b0;
            ext_q     <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            s1_q      <= bus.adc_dat_i;
            dec_cnt_q <= dec_cnt_d;
            wpnt_q    <= wpnt_d;
            tpnt_q    <= tpnt_d;
            dly_q     <= dly_d;
            seen_q    <= seen_d;
            rf_r_q    <= rf_r_d;
            rf_f_q    <= rf_f_d;
            ext_q     <= bus.trig_ext_i;
            trig_q    <= accept;
        end
    end

    // ---------------- write data path ----------------
`ifdef ACQ_AVG_EN
    logic signed [30:0] sum_q, sum_tot, avg_shr;
    logic [4:0]         shamt;
    logic [13:0]        avg_sat;
    logic               wr_en_q;
    logic [RSZ-1:0]     wr_addr_q;
    logic [13:0]        wr_dat_q;

    // floor(log2 N): exact mean for power-of-two N, saturated otherwise
    always_comb begin
        shamt = '0;
        for (int i = 0; i < 17; i++) begin
            if (dec_n[i]) shamt = 5'(i);
        end
    end

    assign sum_tot = sum_q + {{17{s1_q[13]}}, s1_q};
    assign avg_shr = sum_tot >>> shamt;

    always_comb begin
        if (avg_shr > 31'sd8191)       avg_sat = 14'h1FFF;
        else if (avg_shr < -31'sd8192) avg_sat = 14'h2000;
        else                           avg_sat = avg_shr[13:0];
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            sum_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            sum_q     <= (!active || strobe || bus.set_arm_i || bus.set_rst_i) ? '0 : sum_tot;
            wr_en_q   <= strobe;
            wr_addr_q <= wpnt_q;
            wr_dat_q  <= avg_sat;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_dat  = wr_dat_q;
`else
    assign wr_en   = strobe;
    assign wr_addr = wpnt_q;
    assign wr_dat  = s1_q;
`endif

    // ---------------- buffer ----------------
    always_ff @(posedge adc_clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    // read-before-write: a same-address write in this cycle is not visible yet
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) rdata_q <= '0;
        else           rdata_q <= mem[bus.buf_addr_i];
    end

    assign bus.buf_rdata_o = rdata_q;
    assign bus.buf_wpnt_o  = wpnt_q;
    assign bus.trig_pnt_o  = tpnt_q;
    assign bus.trig_o      = trig_q;
endmodule

// File: tb/tb_red_pitaya_acq_ch.sv
// Testbench for red_pitaya_acq_ch (RSZ=4): directed scenarios plus randomized episodes,
// every cycle compared against a behavioural model of the capture rules.
module tb_red_pitaya_acq_ch;
    localparam int RSZ   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    red_pitaya_acq_ch_if #(.RSZ(RSZ)) bus ();

    red_pitaya_acq_ch #(.RSZ(RSZ)) dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // state: 0 idle, 1 armed, 2 triggered, 3 done
    int m_s1, m_st, m_dec, m_wp, m_tp, m_dly, m_rd;
    bit m_rfr, m_rff, m_extp, m_seen, m_trig, m_rd_val;
    int m_mem [DEPTH];
    bit m_val [DEPTH];
    int n_trig = 0;
    int ramp = 0;
    bit ramp_en = 0, rnd_en = 0;

    task automatic model_reset();
        m_s1 = 0; m_st = 0; m_dec = 0; m_wp = 0; m_tp = 0; m_dly = 0;
        m_rfr = 0; m_rff = 0; m_extp = 0; m_seen = 0; m_trig = 0;
        m_rd = 0; m_rd_val = 1;
        for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    endtask

    task automatic model_edge();
        int n, thr, hyst, addr;
        bit arm, sr, act, stb, ev, rise, fall, acc;
        n    = (bus.set_dec_i == 0) ? 1 : int'(bus.set_dec_i);
        thr  = $signed(bus.set_tresh_i);
        hyst = int'(bus.set_hyst_i);
        arm  = bus.set_arm_i;
        sr   = bus.set_rst_i;
        act  = (m_st == 1) || (m_st == 2);
        stb  = act && !arm && !sr && (m_dec == n - 1);
        rise = m_rfr && (m_s1 >= thr);
        fall = m_rff && (m_s1 <= thr);
        case (bus.trig_src_i)
            3'd1:    ev = bus.trig_sw_i;
            3'd2:    ev = rise;
            3'd3:    ev = fall;
            3'd4:    ev = bus.trig_ext_i && !m_extp;
            3'd5:    ev = !bus.trig_ext_i && m_extp;
            default: ev = 0;
        endcase
        acc = (m_st == 1) && ev && !arm && !sr;
        // old contents are read before this cycle's write
        addr = int'(bus.buf_addr_i);
        m_rd_val = m_val[addr];
        m_rd = m_mem[addr];
        if (stb) begin
            m_mem[m_wp] = m_s1;
            m_val[m_wp] = 1;
        end
        if (arm) begin
            m_rfr = 0; m_rff = 0;
        end else begin
            if (m_s1 < thr - hyst) m_rfr = 1; else if (rise) m_rfr = 0;
            if (m_s1 > thr + hyst) m_rff = 1; else if (fall) m_rff = 0;
        end
        m_extp = bus.trig_ext_i;
        m_trig = acc;
        if (sr) begin
            m_st = 0; m_wp = 0; m_tp = 0; m_dec = 0; m_dly = 0; m_seen = 0;
        end else if (arm) begin
            m_st = 1; m_dec = 0; m_dly = 0; m_seen = 0;
        end else begin
            m_dec = (act && !stb) ? m_dec + 1 : 0;
            if (acc) begin
                m_tp  = m_seen ? (m_wp + DEPTH - 1) % DEPTH : m_wp;
                m_dly = int'(bus.set_dly_i);
                m_st  = (m_dly == 0) ? 3 : 2;
            end else if (m_st == 2 && stb) begin
                m_dly = m_dly - 1;
                if (m_dly <= 0) m_st = 3;
            end
            if (stb) begin
                m_wp = (m_wp + 1) % DEPTH;
                m_seen = 1;
            end
        end
        m_s1 = $signed(bus.adc_dat_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge,
    // then pulses are dropped and the next sample is presented.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        chk("sts_armed", 32'(bus.sts_armed_o), 32'(m_st == 1 || m_st == 2));
        chk("sts_done",  32'(bus.sts_done_o),  32'(m_st == 3));
        chk("trig_o",    32'(bus.trig_o),      32'(m_trig));
        chk("buf_wpnt",  32'(bus.buf_wpnt_o),  32'(m_wp));
        chk("trig_pnt",  32'(bus.trig_pnt_o),  32'(m_tp));
`ifndef ACQ_AVG_EN
        if (m_rd_val) chk("buf_rdata", 32'(bus.buf_rdata_o), 32'(m_rd) & 32'h3FFF);
`endif
        if (bus.trig_o === 1'b1) n_trig++;
        bus.set_arm_i = 0;
        bus.set_rst_i = 0;
        bus.trig_sw_i = 0;
        if (ramp_en) begin
            bus.adc_dat_i = 14'(ramp);
            ramp++;
        end else if (rnd_en) begin
            bus.adc_dat_i = 14'($urandom_range(0, 6000) - 3000);
        end
    endtask

    task automatic fsm_rst();
        bus.set_rst_i = 1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp0, n, a, b;
        logic [RSZ-1:0] w;
        bus.adc_dat_i = 0; bus.trig_sw_i = 0; bus.trig_ext_i = 0; bus.trig_src_i = 0;
        bus.set_arm_i = 0; bus.set_rst_i = 0; bus.set_dec_i = 1; bus.set_tresh_i = 0;
        bus.set_hyst_i = 0; bus.set_dly_i = 0; bus.buf_addr_i = 0;
        model_reset();

        // reset state
        cyc(); cyc();
        rst = 0;
        cyc();

        // software trigger, N=1, 100 post-trigger samples on a ramp
        bus.trig_src_i = 1; bus.set_dly_i = 100; bus.set_dec_i = 1;
        ramp = 0; ramp_en = 1;
        repeat (5) cyc();
        bus.set_arm_i = 1; cyc();
        n = 0;
        while (bus.adc_dat_i != 14'd500 && n < 1000) begin cyc(); n++; end
        chk("sw_ramp_reach", 32'(bus.adc_dat_i), 32'd500);
        wp0 = m_wp;
        n_trig = 0;
        bus.trig_sw_i = 1; cyc();
        repeat (110) cyc();
        chk("sw_trig_count", 32'(n_trig), 32'd1);
        chk("sw_done", 32'(bus.sts_done_o), 32'd1);
        chk("sw_final_wpnt", 32'(bus.buf_wpnt_o), 32'((wp0 + 101) % DEPTH));
        w = bus.buf_wpnt_o;
        repeat (4) cyc();
        chk("sw_wpnt_frozen", 32'(bus.buf_wpnt_o), 32'(w));

        // level rising trigger with hysteresis
        ramp_en = 0;
        fsm_rst();
        bus.trig_src_i = 2; bus.set_tresh_i = 14'd1000; bus.set_hyst_i = 14'd50; bus.set_dly_i = 5;
        bus.adc_dat_i = 0; repeat (2) cyc();
        bus.adc_dat_i = 990; bus.set_arm_i = 1; cyc();
        n_trig = 0;
        repeat (2) cyc();
        bus.adc_dat_i = 1010; repeat (3) cyc();
        chk("lvl_no_trig_without_rearm", 32'(n_trig), 32'd0);
        bus.adc_dat_i = 900; repeat (2) cyc();
        bus.adc_dat_i = 1000; repeat (3) cyc();
        chk("lvl_trig_on_1000", 32'(n_trig), 32'd1);
        bus.adc_dat_i = 980; repeat (2) cyc();
        bus.adc_dat_i = 1010; repeat (8) cyc();
        chk("lvl_no_second_trig", 32'(n_trig), 32'd1);
        chk("lvl_done", 32'(bus.sts_done_o), 32'd1);

        // decimation N=4, 3 post-trigger samples
        fsm_rst();
        bus.trig_src_i = 1; bus.set_dec_i = 4; bus.set_dly_i = 3;
        ramp = 0; ramp_en = 1;
        bus.set_arm_i = 1; cyc();
        repeat (20) cyc();
        bus.trig_sw_i = 1; cyc();
        chk("dec_trig_pulse", 32'(bus.trig_o), 32'd1);
        n = 0;
        while (bus.sts_done_o !== 1'b1 && n < 40) begin cyc(); n++; end
        chk("dec_done_latency", 32'(n >= 9 && n <= 15), 32'd1);
        ramp_en = 0;
        repeat (2) cyc();
        bus.buf_addr_i = 4'((m_wp + DEPTH - 1) % DEPTH); cyc();
        a = int'(bus.buf_rdata_o);
        bus.buf_addr_i = 4'((m_wp + DEPTH - 2) % DEPTH); cyc();
        b = int'(bus.buf_rdata_o);
        chk("dec_sample_step", 32'((a - b) & 16'h3FFF), 32'd4);

        // wrap: 20 strobes into a 16-deep buffer
        fsm_rst();
        bus.set_dec_i = 1; bus.set_dly_i = 0; bus.trig_src_i = 1;
        bus.adc_dat_i = 0; ramp = 1; ramp_en = 1;
        bus.set_arm_i = 1; cyc();
        repeat (19) cyc();
        bus.trig_sw_i = 1; cyc();
        chk("wrap_wpnt", 32'(bus.buf_wpnt_o), 32'd4);
        chk("wrap_done", 32'(bus.sts_done_o), 32'd1);
        ramp_en = 0;
        for (int i = 0; i < 4; i++) begin
            bus.buf_addr_i = 4'(i);
            cyc();
            chk("wrap_readback", 32'(bus.buf_rdata_o), 32'(16 + i));
        end

        // same-address read while writing returns the old value
        bus.trig_src_i = 0; bus.buf_addr_i = 4; bus.adc_dat_i = 14'd1000;
        bus.set_arm_i = 1; cyc();
        cyc();
        chk("rw_same_addr_old", 32'(bus.buf_rdata_o), 32'd4);
        cyc();
`ifndef ACQ_AVG_EN
        chk("rw_same_addr_new", 32'(bus.buf_rdata_o), 32'd1000);
`endif

        // set_rst_i beats a simultaneous arm and trigger
        bus.trig_src_i = 1;
        bus.set_rst_i = 1; bus.set_arm_i = 1; bus.trig_sw_i = 1; cyc();
        chk("prio_armed", 32'(bus.sts_armed_o), 32'd0);
        chk("prio_done", 32'(bus.sts_done_o), 32'd0);
        chk("prio_trig", 32'(bus.trig_o), 32'd0);
        chk("prio_wpnt", 32'(bus.buf_wpnt_o), 32'd0);
        cyc();
        chk("prio_trig_late", 32'(bus.trig_o), 32'd0);

        // asynchronous reset while triggered
        bus.set_dly_i = 50; rnd_en = 1;
        bus.set_arm_i = 1; cyc();
        repeat (3) cyc();
        bus.trig_sw_i = 1; cyc();
        repeat (3) cyc();
        chk("pre_rst_trigd", 32'(bus.sts_armed_o), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_armed", 32'(bus.sts_armed_o), 32'd0);
        chk("arst_done", 32'(bus.sts_done_o), 32'd0);
        chk("arst_trig", 32'(bus.trig_o), 32'd0);
        chk("arst_wpnt", 32'(bus.buf_wpnt_o), 32'd0);
        chk("arst_tpnt", 32'(bus.trig_pnt_o), 32'd0);
        chk("arst_rdata", 32'(bus.buf_rdata_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cyc();
        chk("post_rst_idle", 32'(bus.sts_armed_o | bus.sts_done_o), 32'd0);
        chk("post_rst_wpnt", 32'(bus.buf_wpnt_o), 32'd0);

        // randomized episodes against the model
        for (int ep = 0; ep < 25; ep++) begin
            bus.trig_src_i  = 3'($urandom_range(0, 7));
            bus.set_dec_i   = 17'($urandom_range(0, 3));
            bus.set_dly_i   = $urandom_range(0, 12);
            bus.set_tresh_i = 14'($urandom_range(0, 3000) - 1500);
            bus.set_hyst_i  = 14'($urandom_range(0, 300));
            bus.set_arm_i = 1; cyc();
            for (int c = 0; c < 120; c++) begin
                bus.trig_sw_i  = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 7) == 0) bus.trig_ext_i = ~bus.trig_ext_i;
                bus.set_arm_i  = ($urandom_range(0, 79) == 0);
                bus.set_rst_i  = ($urandom_range(0, 299) == 0);
                bus.buf_addr_i = 4'($urandom_range(0, 15));
                cyc();
            end
        end
        rnd_en = 0;

`ifdef ACQ_AVG_EN
        // averaging with N=8 on full-scale negative input must not overflow
        fsm_rst();
        bus.set_dec_i = 8; bus.set_dly_i = 0; bus.trig_src_i = 1; bus.adc_dat_i = 14'h2000;
        bus.set_arm_i = 1; cyc();
        repeat (30) cyc();
        bus.trig_sw_i = 1; cyc();
        repeat (3) cyc();
        bus.buf_addr_i = 4'((m_wp + DEPTH - 1) % DEPTH);
        cyc(); cyc();
        chk("avg_neg_fullscale", 32'(bus.buf_rdata_o), 32'h2000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
